// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the fetch/decode front end: decoded opcode
// enumeration, opcode byte values and instruction field positions.
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_BRANCH,
        I_BZERO,
        I_BNEG,
        I_BOV,
        I_BNOV,
        I_BNNEG,
        I_BNZERO,
        I_HALT
    } decoded_instruction_type;

    localparam logic [7:0] OPC_LOAD   = 8'h81;
    localparam logic [7:0] OPC_STORE  = 8'h82;
    localparam logic [7:0] OPC_MOVE   = 8'h91;
    localparam logic [7:0] OPC_ADD    = 8'hA1;
    localparam logic [7:0] OPC_SUB    = 8'hA2;
    localparam logic [7:0] OPC_AND    = 8'hA3;
    localparam logic [7:0] OPC_OR     = 8'hA4;
    localparam logic [7:0] OPC_BRANCH = 8'h01;
    localparam logic [7:0] OPC_BZERO  = 8'h02;
    localparam logic [7:0] OPC_BNEG   = 8'h03;
    localparam logic [7:0] OPC_BOV    = 8'h05;
    localparam logic [7:0] OPC_BNOV   = 8'h06;
    localparam logic [7:0] OPC_BNNEG  = 8'h0A;
    localparam logic [7:0] OPC_BNZERO = 8'h0B;
    localparam logic [7:0] OPC_HALT   = 8'hFF;

    localparam int OPC_MSB     = 15;
    localparam int OPC_LSB     = 8;
    localparam int ALU_C_LSB   = 4;
    localparam int ALU_A_LSB   = 2;
    localparam int ALU_B_LSB   = 0;
    localparam int MOVE_C_LSB  = 2;
    localparam int MOVE_A_LSB  = 0;
    localparam int MEM_REG_LSB = 5;

    // Undefined opcode bytes map to I_NOP; no real opcode decodes to I_NOP.
    function automatic decoded_instruction_type decode_opcode(input logic [7:0] opc);
        case (opc)
            OPC_LOAD:   return I_LOAD;
            OPC_STORE:  return I_STORE;
            OPC_MOVE:   return I_MOVE;
            OPC_ADD:    return I_ADD;
            OPC_SUB:    return I_SUB;
            OPC_AND:    return I_AND;
            OPC_OR:     return I_OR;
            OPC_BRANCH: return I_BRANCH;
            OPC_BZERO:  return I_BZERO;
            OPC_BNEG:   return I_BNEG;
            OPC_BOV:    return I_BOV;
            OPC_BNOV:   return I_BNOV;
            OPC_BNNEG:  return I_BNNEG;
            OPC_BNZERO: return I_BNZERO;
            OPC_HALT:   return I_HALT;
            default:    return I_NOP;
        endcase
    endfunction

    function automatic logic opcode_defined(input logic [7:0] opc);
        return decode_opcode(opc) != I_NOP;
    endfunction

endpackage

// File: rtl/fetch_decode_unit_if.sv
// Control/RAM/decode bundle around the fetch/decode unit.
// illegal_op exists only when FD_ILLEGAL_TRAP_EN is defined.
interface fetch_decode_if
    import k_and_s_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) ();

    logic                    branch;
    logic                    pc_enable;
    logic                    ir_enable;
    logic                    addr_sel;
    logic [DATA_W-1:0]       ram_data_in;
    logic [ADDR_W-1:0]       ram_addr;
    decoded_instruction_type decoded_instruction;
    logic [1:0]              a_addr;
    logic [1:0]              b_addr;
    logic [1:0]              c_addr;
    logic [ADDR_W-1:0]       pc_out;
    logic [CNT_W-1:0]        fetch_count;
`ifdef FD_ILLEGAL_TRAP_EN
    logic                    illegal_op;
`endif

    modport slave (
`ifdef FD_ILLEGAL_TRAP_EN
        output illegal_op,
`endif
        input  branch, pc_enable, ir_enable, addr_sel, ram_data_in,
        output ram_addr, decoded_instruction, a_addr, b_addr, c_addr,
               pc_out, fetch_count
    );

    modport master (
`ifdef FD_ILLEGAL_TRAP_EN
        input  illegal_op,
`endif
        output branch, pc_enable, ir_enable, addr_sel, ram_data_in,
        input  ram_addr, decoded_instruction, a_addr, b_addr, c_addr,
               pc_out, fetch_count
    );

endinterface

// File: rtl/fetch_decode_unit_decoder.sv
// Combinational instruction decoder: registered IR in, opcode and register
// file addresses out. FD_ILLEGAL_TRAP_EN turns undefined opcodes into I_HALT.
module instruction_decoder
    import k_and_s_pkg::*;
(
    input  logic [15:0]             ir,
`ifdef FD_ILLEGAL_TRAP_EN
    input  logic                    ir_valid,
`endif
    output decoded_instruction_type decoded_instruction,
    output logic [1:0]              a_addr,
    output logic [1:0]              b_addr,
    output logic [1:0]              c_addr
);

    decoded_instruction_type opc_dec;
    logic                    unused_ir_bit;

    assign unused_ir_bit = ir[7];

    always_comb begin
        opc_dec             = decode_opcode(ir[OPC_MSB:OPC_LSB]);
        decoded_instruction = opc_dec;
        a_addr              = 2'b00;
        b_addr              = 2'b00;
        c_addr              = 2'b00;

`ifdef FD_ILLEGAL_TRAP_EN
        // The reset value of IR was never fetched, so it stays a plain NOP.
        if (opc_dec == I_NOP && ir_valid) begin
            decoded_instruction = I_HALT;
        end
`endif

        case (opc_dec)
            I_ADD, I_SUB, I_AND, I_OR: begin
                c_addr = ir[ALU_C_LSB +: 2];
                a_addr = ir[ALU_A_LSB +: 2];
                b_addr = ir[ALU_B_LSB +: 2];
            end
            I_MOVE: begin
                c_addr = ir[MOVE_C_LSB +: 2];
                a_addr = ir[MOVE_A_LSB +: 2];
                b_addr = ir[MOVE_A_LSB +: 2];
            end
            I_LOAD:  c_addr = ir[MEM_REG_LSB +: 2];
            I_STORE: a_addr = ir[MEM_REG_LSB +: 2];
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_decode_unit.sv
// Datapath front end: PC, IR, RAM address mux, retired-fetch counter and decoder.
// Optional sticky illegal-opcode trap under FD_ILLEGAL_TRAP_EN.
module fetch_decode_unit
    import k_and_s_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    fetch_decode_if.slave bus
);

    logic [ADDR_W-1:0]       pc;
    logic [DATA_W-1:0]       ir;
    logic [CNT_W-1:0]        fetch_count;
    logic [ADDR_W-1:0]       ir_target;
    decoded_instruction_type dec_op;
    logic [1:0]              dec_a;
    logic [1:0]              dec_b;
    logic [1:0]              dec_c;

    assign ir_target = ir[ADDR_W-1:0];

    // Branch target always comes from the IR value held before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (bus.pc_enable) begin
            pc <= bus.branch ? ir_target : pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir <= '0;
        end else if (bus.ir_enable) begin
            ir <= bus.ram_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (bus.ir_enable && (fetch_count != {CNT_W{1'b1}})) begin
            fetch_count <= fetch_count + CNT_W'(1);
        end
    end

`ifdef FD_ILLEGAL_TRAP_EN
    logic ir_valid;
    logic illegal_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_valid   <= 1'b0;
            illegal_op <= 1'b0;
        end else if (bus.ir_enable) begin
            ir_valid <= 1'b1;
            if (!opcode_defined(bus.ram_data_in[OPC_MSB:OPC_LSB])) begin
                illegal_op <= 1'b1;
            end
        end
    end

    assign bus.illegal_op = illegal_op;
`endif

    instruction_decoder u_decoder (
        .ir                  (ir),
`ifdef FD_ILLEGAL_TRAP_EN
        .ir_valid            (ir_valid),
`endif
        .decoded_instruction (dec_op),
        .a_addr              (dec_a),
        .b_addr              (dec_b),
        .c_addr              (dec_c)
    );

    assign bus.ram_addr            = bus.addr_sel ? ir_target : pc;
    assign bus.decoded_instruction = dec_op;
    assign bus.a_addr              = dec_a;
    assign bus.b_addr              = dec_b;
    assign bus.c_addr              = dec_c;
    assign bus.pc_out              = pc;
    assign bus.fetch_count         = fetch_count;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed self-checking bench for fetch_decode_unit (default and
// FD_ILLEGAL_TRAP_EN builds).
module tb_fetch_decode_unit;
    import k_and_s_pkg::*;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 16;

`ifdef FD_ILLEGAL_TRAP_EN
    localparam decoded_instruction_type UNDEF_OP = I_HALT;
`else
    localparam decoded_instruction_type UNDEF_OP = I_NOP;
`endif

    typedef struct {
        logic [15:0]             ir;
        decoded_instruction_type op;
        logic [1:0]              c;
        logic [1:0]              a;
        logic [1:0]              b;
    } dec_vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;
    logic [15:0] ram [32];

    always #5 clk = ~clk;

    fetch_decode_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    fetch_decode_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.ram_data_in = ram[bus.ram_addr];

    dec_vec_t vecs [16] = '{
        '{16'hA22D, I_SUB,    2'd2, 2'd3, 2'd1},
        '{16'hA336, I_AND,    2'd3, 2'd1, 2'd2},
        '{16'hA409, I_OR,     2'd0, 2'd2, 2'd1},
        '{16'h910E, I_MOVE,   2'd3, 2'd2, 2'd2},
        '{16'h8260, I_STORE,  2'd0, 2'd3, 2'd0},
        '{16'h81FF, I_LOAD,   2'd3, 2'd0, 2'd0},
        '{16'h01FF, I_BRANCH, 2'd0, 2'd0, 2'd0},
        '{16'h023F, I_BZERO,  2'd0, 2'd0, 2'd0},
        '{16'h033F, I_BNEG,   2'd0, 2'd0, 2'd0},
        '{16'h053F, I_BOV,    2'd0, 2'd0, 2'd0},
        '{16'h063F, I_BNOV,   2'd0, 2'd0, 2'd0},
        '{16'h0A3F, I_BNNEG,  2'd0, 2'd0, 2'd0},
        '{16'h0B3F, I_BNZERO, 2'd0, 2'd0, 2'd0},
        '{16'h0400, UNDEF_OP, 2'd0, 2'd0, 2'd0},
        '{16'hA03F, UNDEF_OP, 2'd0, 2'd0, 2'd0},
        '{16'hFF3F, I_HALT,   2'd0, 2'd0, 2'd0}
    };

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_dec(input string tag, input decoded_instruction_type op,
                             input logic [1:0] c, input logic [1:0] a, input logic [1:0] b);
        check({tag, " op"}, 32'(bus.decoded_instruction), 32'(op));
        check({tag, " c"},  32'(bus.c_addr), 32'(c));
        check({tag, " a"},  32'(bus.a_addr), 32'(a));
        check({tag, " b"},  32'(bus.b_addr), 32'(b));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.branch    = 1'b0;
        bus.pc_enable = 1'b0;
        bus.ir_enable = 1'b0;
    endtask

    task automatic pc_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            bus.pc_enable = 1'b1;
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 16'h0000;
        rst           = 1'b1;
        bus.branch    = 1'b0;
        bus.pc_enable = 1'b0;
        bus.ir_enable = 1'b0;
        bus.addr_sel  = 1'b0;
        tick();

        check_dec("reset", I_NOP, 2'd0, 2'd0, 2'd0);
        check("reset pc", 32'(bus.pc_out), 32'd0);
        check("reset fetch_count", 32'(bus.fetch_count), 32'd0);
        check("reset ram_addr", 32'(bus.ram_addr), 32'd0);
`ifdef FD_ILLEGAL_TRAP_EN
        check("reset illegal_op", 32'(bus.illegal_op), 32'd0);
`endif

        // Three fetches from RAM[0..2]
        ram[0] = 16'hA11B;
        ram[1] = 16'h8145;
        ram[2] = 16'hFF00;
        bus.ir_enable = 1'b1; bus.pc_enable = 1'b1; tick();
        check_dec("fetch0", I_ADD, 2'd1, 2'd2, 2'd3);
        check("fetch0 pc", 32'(bus.pc_out), 32'd1);
        check("fetch0 count", 32'(bus.fetch_count), 32'd1);
        bus.ir_enable = 1'b1; bus.pc_enable = 1'b1; tick();
        check_dec("fetch1", I_LOAD, 2'd2, 2'd0, 2'd0);
        bus.addr_sel = 1'b1; #1;
        check("ram_addr from ir", 32'(bus.ram_addr), 32'd5);
        bus.addr_sel = 1'b0; #1;
        check("ram_addr from pc", 32'(bus.ram_addr), 32'd2);
        bus.ir_enable = 1'b1; bus.pc_enable = 1'b1; tick();
        check_dec("fetch2", I_HALT, 2'd0, 2'd0, 2'd0);
        check("fetch2 pc", 32'(bus.pc_out), 32'd3);
        check("fetch2 count", 32'(bus.fetch_count), 32'd3);

        // Branch from pc=7 with IR=0x0112
        pc_pulses(4);
        check("pc advance", 32'(bus.pc_out), 32'd7);
        ram[7] = 16'h0112;
        bus.ir_enable = 1'b1; tick();
        check("ir-only pc hold", 32'(bus.pc_out), 32'd7);
        check_dec("branch ir", I_BRANCH, 2'd0, 2'd0, 2'd0);
        bus.branch = 1'b1; bus.pc_enable = 1'b1; tick();
        check("branch taken", 32'(bus.pc_out), 32'd18);

        // Wrap 31 -> 0 with nothing else moving
        pc_pulses(13);
        check("pc at 31", 32'(bus.pc_out), 32'd31);
        bus.pc_enable = 1'b1; tick();
        check("pc wrap", 32'(bus.pc_out), 32'd0);
        check("wrap count", 32'(bus.fetch_count), 32'd4);
        check_dec("wrap ir", I_BRANCH, 2'd0, 2'd0, 2'd0);
        pc_pulses(7);
        bus.branch = 1'b0; bus.pc_enable = 1'b1; tick();
        check("no-branch increment", 32'(bus.pc_out), 32'd8);
        bus.branch = 1'b1; tick();
        check("branch w/o pc_enable", 32'(bus.pc_out), 32'd8);

        // Simultaneous fetch and branch: target comes from the old IR
        ram[8] = 16'h0115;
        bus.ir_enable = 1'b1; bus.pc_enable = 1'b1; bus.branch = 1'b1; tick();
        check("fetch+branch pc", 32'(bus.pc_out), 32'd18);
        check("fetch+branch count", 32'(bus.fetch_count), 32'd5);
        bus.addr_sel = 1'b1; #1;
        check("new ir target", 32'(bus.ram_addr), 32'd21);
        bus.addr_sel = 1'b0; #1;

        // Decode table, IR loads only
        foreach (vecs[i]) begin
            ram[bus.ram_addr] = vecs[i].ir;
            bus.ir_enable = 1'b1; tick();
            check_dec($sformatf("dec %04h", vecs[i].ir), vecs[i].op, vecs[i].c, vecs[i].a, vecs[i].b);
        end
        check("table pc", 32'(bus.pc_out), 32'd18);
        check("table count", 32'(bus.fetch_count), 32'd21);

        // Undefined opcode and trap behaviour
        ram[bus.ram_addr] = 16'h7700;
        bus.ir_enable = 1'b1; tick();
        check_dec("undef 7700", UNDEF_OP, 2'd0, 2'd0, 2'd0);
`ifdef FD_ILLEGAL_TRAP_EN
        check("illegal set", 32'(bus.illegal_op), 32'd1);
`endif
        ram[bus.ram_addr] = 16'hA11B;
        bus.ir_enable = 1'b1; bus.pc_enable = 1'b1; tick();
        check_dec("after undef", I_ADD, 2'd1, 2'd2, 2'd3);
`ifdef FD_ILLEGAL_TRAP_EN
        check("illegal sticky", 32'(bus.illegal_op), 32'd1);
`endif

        // Reset wins over strobes mid-program
        ram[bus.ram_addr] = 16'hA22D;
        rst = 1'b1; bus.ir_enable = 1'b1; bus.pc_enable = 1'b1; tick();
        check("rst pc", 32'(bus.pc_out), 32'd0);
        check("rst count", 32'(bus.fetch_count), 32'd0);
        check_dec("rst dec", I_NOP, 2'd0, 2'd0, 2'd0);
        bus.addr_sel = 1'b1; #1;
        check("rst ir zero", 32'(bus.ram_addr), 32'd0);
        bus.addr_sel = 1'b0; #1;
`ifdef FD_ILLEGAL_TRAP_EN
        check("rst illegal", 32'(bus.illegal_op), 32'd0);
`endif

        // Counter saturation
        ram[0] = 16'hA11B;
        bus.ir_enable = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        bus.ir_enable = 1'b0;
        check("count near max", 32'(bus.fetch_count), 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            bus.ir_enable = 1'b1; tick();
            check($sformatf("count sat %0d", i), 32'(bus.fetch_count), 32'hFFFF);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_decode_unit.md
Name: fetch_decode_unit

Overview:
- Datapath front end: program counter (PC), instruction register (IR), RAM address mux and instruction decoder.
- Consumes the control unit's branch, pc_enable, ir_enable and addr_sel strobes.
- Produces decoded_instruction and register-file operand addresses for the control unit and the register file/ALU.
- Sits between the program/data RAM read port and the control unit.

Parameters:
- ADDR_W, 5: RAM address width; PC and branch target width.
- DATA_W, 16: instruction/RAM word width; fixed encoding requires 16.
- CNT_W, 16: width of the retired-fetch counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- branch  in  1  PC load source: 1 = IR[ADDR_W-1:0], 0 = PC+1.
- pc_enable  in  1  PC update strobe.
- ir_enable  in  1  IR load strobe; IR <= ram_data_in.
- addr_sel  in  1  RAM address source: 1 = IR[ADDR_W-1:0], 0 = PC.
- ram_data_in  in  DATA_W  RAM read data.
- ram_addr  out  ADDR_W  RAM address, combinational mux.
- decoded_instruction  out  decoded_instruction_type  opcode decoded from the registered IR.
- a_addr  out  2  register-file read port A.
- b_addr  out  2  register-file read port B.
- c_addr  out  2  register-file write address.
- pc_out  out  ADDR_W  current PC, for debug.
- fetch_count  out  CNT_W  count of IR loads since reset.
- illegal_op  out  1  sticky illegal-opcode flag; only when FD_ILLEGAL_TRAP_EN is defined.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc=0, ir=16'h0000, fetch_count=0, illegal_op=0.
  - decoded_instruction=I_NOP, a_addr/b_addr/c_addr=0.
  - Reset wins over every strobe in the same cycle. Reset mid-program aborts the instruction; the next fetch is from address 0.
- ram_addr: addr_sel ? ir[ADDR_W-1:0] : pc. Zero latency.
- PC:
  - If pc_enable, pc <= branch ? ir[ADDR_W-1:0] : pc+1.
  - Increment wraps 31 -> 0 (modulo 2^ADDR_W). No flag on wrap.
  - branch with pc_enable=0 has no effect.
- IR: if ir_enable, ir <= ram_data_in.
- ir_enable and pc_enable in the same cycle:
  - IR captures the word at the old PC.
  - PC advances. If branch=1 in that cycle, the target comes from the old IR.
- Decode:
  - Combinational from the registered IR only. New IR contents appear as decoded_instruction one cycle after ir_enable.
  - Outputs stay stable while IR holds.
- Opcode encodings, ir[15:8]:
  - 8'h81 I_LOAD, 8'h82 I_STORE, 8'h91 I_MOVE.
  - 8'hA1 I_ADD, 8'hA2 I_SUB, 8'hA3 I_AND, 8'hA4 I_OR.
  - 8'h01 I_BRANCH, 8'h02 I_BZERO, 8'h03 I_BNEG, 8'h05 I_BOV, 8'h06 I_BNOV, 8'h0A I_BNNEG, 8'h0B I_BNZERO.
  - 8'hFF I_HALT.
  - Any other value is I_NOP (no trap build).
- Field extraction:
  - ALU ops: c_addr=ir[5:4], a_addr=ir[3:2], b_addr=ir[1:0].
  - MOVE: c_addr=ir[3:2], a_addr=ir[1:0], b_addr=ir[1:0].
  - LOAD: c_addr=ir[6:5].
  - STORE: a_addr=ir[6:5].
  - Every field not listed for an opcode drives 0.
- fetch_count: +1 on each ir_enable; saturates at all-ones, no wrap.

Optional Feature:
- Macro: FD_ILLEGAL_TRAP_EN.
- Defined:
  - An undefined opcode in IR decodes as I_HALT.
  - illegal_op is set the cycle after that IR load and stays set until rst.
  - ir=16'h0000 straight after reset does not set illegal_op; it decodes as I_NOP.
- Undefined: the illegal_op port is absent and undefined opcodes decode as I_NOP.

Decomposition:
- k_and_s_pkg holds:
  - decoded_instruction_type, with I_NOP added.
  - Opcode localparams OPC_LOAD … OPC_HALT.
  - Field bit-position constants.
- One sub-module, instruction_decoder: purely combinational; IR in, decoded_instruction and a/b/c addresses out.
- PC, IR, counter and flag logic stay in fetch_decode_unit.

Test Plan:
- Reset, then three ir_enable+pc_enable pulses with RAM[0..2]=16'hA1_1B, 16'h81_45, 16'hFF_00:
  - After the first pulse, decode is I_ADD with c=1, a=2, b=3.
  - Then I_LOAD with c=2, ram_addr=5 when addr_sel=1.
  - Then I_HALT; pc=3, fetch_count=3.
- IR=16'h0112, pc=7, branch=1, pc_enable=1 -> pc=18 next cycle. Same with branch=0 -> pc=8.
- pc=31, pc_enable=1, branch=0 -> pc=0; no other state changes.
- rst=1 asserted together with ir_enable/pc_enable mid-program -> pc=0, ir=0, I_NOP, fetch_count=0 next cycle.
- Load IR=16'h7700 -> I_NOP, illegal_op=0 without the macro. With FD_ILLEGAL_TRAP_EN: I_HALT, illegal_op=1, held through later fetches until rst.
- Force fetch_count to all-ones minus 1, pulse ir_enable three times -> stays at 16'hFFFF.
